mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result (address), store data, and load/store control fields.
- Drives a req/ready data-memory port, performs byte/half/word lane steering and load sign/zero extension, and stalls the pipeline until the access completes.
- Produces load data for the MEM/WB register.

---
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ready port, byte/half/word lane steering,
// load extension and pipeline stall.
// Optional feature: define DMEM_TIMEOUT_EN to abort accesses that see no ready for
// TIMEOUT_CYCLES cycles. Without it, BUSY waits indefinitely and o_bus_err is tied to 0.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [STRB_WIDTH-1:0] o_dmem_wstrb,
  input  logic                  i_dmem_ready,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata
);

  if (DATA_WIDTH != 32 || STRB_WIDTH != DATA_WIDTH / 8 || TIMEOUT_CYCLES == 0) begin : g_param_err
    $error("mem_access_unit: unsupported parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    mis_q, mis_d;
  logic                    bus_err_q, bus_err_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              f3_q, f3_d;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0]         cnt_q, cnt_d;
`endif

  logic                    acc, is_byte, is_half, misaligned;
  logic [DATA_WIDTH-1:0]   st_wdata, ld_shift, ld_data;
  logic [STRB_WIDTH-1:0]   st_wstrb;

  // Access decode, alignment check and store lane steering from the EX/MEM inputs
  always_comb begin
    acc     = i_valid & (i_mem_read | i_mem_write);
    is_byte = (i_funct3 == 3'b000) || (i_funct3 == 3'b100);
    is_half = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    // Undefined funct3 encodings fall through to word handling
    if (is_byte)      misaligned = 1'b0;
    else if (is_half) misaligned = i_addr[0];
    else              misaligned = (i_addr[1:0] != 2'b00);
    st_wdata = i_wdata;
    st_wstrb = '1;
    if (is_byte) begin
      st_wdata = {STRB_WIDTH{i_wdata[7:0]}};
      st_wstrb = STRB_WIDTH'(1) << i_addr[1:0];
    end else if (is_half) begin
      st_wdata = {(STRB_WIDTH / 2){i_wdata[15:0]}};
      st_wstrb = STRB_WIDTH'(3) << i_addr[1:0];
    end
  end

  // Load extraction and sign/zero extension using the registered offset and size
  always_comb begin
    ld_shift = i_dmem_rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_data = {{(DATA_WIDTH - 8){ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {{(DATA_WIDTH - 8){1'b0}}, ld_shift[7:0]};
      3'b001:  ld_data = {{(DATA_WIDTH - 16){ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {{(DATA_WIDTH - 16){1'b0}}, ld_shift[15:0]};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mis_d     = 1'b0;
    bus_err_d = 1'b0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    off_d     = off_q;
    f3_d      = f3_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (acc && misaligned) begin
          mis_d = 1'b1;
        end else if (acc) begin
          req_d   = 1'b1;
          we_d    = ~i_mem_read;
          addr_d  = {i_addr[DATA_WIDTH-1:2], 2'b00};
          wdata_d = st_wdata;
          wstrb_d = i_mem_read ? '0 : st_wstrb;
          off_d   = i_addr[1:0];
          f3_d    = i_funct3;
          state_d = StBusy;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        if (i_dmem_ready) begin
          if (!we_q) rdata_d = ld_data;
          req_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = StDone;
`ifdef DMEM_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      mis_q     <= 1'b0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      off_q     <= '0;
      f3_q      <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      mis_q     <= mis_d;
      bus_err_q <= bus_err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Stall covers the accepting IDLE cycle and every BUSY cycle
  always_comb begin
    o_stall = (state_q == StBusy) || ((state_q == StIdle) && acc && !misaligned);
  end

  assign o_rdata      = rdata_q;
  assign o_rvalid     = rvalid_q;
  assign o_misaligned = mis_q;
`ifdef DMEM_TIMEOUT_EN
  assign o_bus_err    = bus_err_q;
`else
  assign o_bus_err    = 1'b0;
`endif
  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand sequences for reset,
// DONE-cycle handling and (when DMEM_TIMEOUT_EN is defined) timeout, plus random accesses
// checked against a size/offset arithmetic model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_mem_read, i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rvalid, o_misaligned, o_bus_err;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_WIDTH    (32),
    .STRB_WIDTH    (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_stall     (o_stall),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_misaligned(o_misaligned),
    .o_bus_err   (o_bus_err),
    .o_dmem_req  (o_dmem_req),
    .o_dmem_we   (o_dmem_we),
    .o_dmem_addr (o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes from funct3
  function automatic int acc_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << acc_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (acc_size(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] mem);
    logic [31:0] v;
    logic        sgn;
    v   = mem >> (8 * (a % 4));
    sgn = (f3 == 3'b000) || (f3 == 3'b001);
    case (acc_size(f3))
      1: begin
        v = v & 32'hFF;
        if (sgn && v >= 32'h80) v = v - 32'h100;
      end
      2: begin
        v = v & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v - 32'h1_0000;
      end
      default: v = mem;
    endcase
    return v;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
    i_funct3 = f3; i_addr = a; i_wdata = wd;
  endtask

  task automatic drive_idle();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = 3'b000; i_addr = $urandom; i_wdata = $urandom;
  endtask

  // One access from IDLE. Ends in IDLE with idle inputs unless hold_in_done is set, in which
  // case the same load is held through DONE and must only start in the following IDLE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mem,
                            input int waits, input logic mis, input logic [3:0] strb,
                            input logic [31:0] ewd, input logic [31:0] erd,
                            input logic hold_in_done);
    int stalls;
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    i_dmem_ready = 1'b0;
    #1;
    if (!(rd || wr)) begin
      chk("noacc_stall", o_stall, 0);
      @(negedge clk); drive_idle(); #1;
      chk("noacc_req", o_dmem_req, 0);
      chk("noacc_mis", o_misaligned, 0);
      chk("noacc_rdata", o_rdata, erd);
      return;
    end
    chk("idle_stall", o_stall, !mis);
    if (mis) begin
      @(negedge clk); drive_idle(); #1;
      chk("mis_pulse", o_misaligned, 1);
      chk("mis_req", o_dmem_req, 0);
      chk("mis_stall", o_stall, 0);
      chk("mis_rvalid", o_rvalid, 0);
      @(negedge clk); #1;
      chk("mis_pulse_end", o_misaligned, 0);
      chk("mis_req2", o_dmem_req, 0);
      chk("mis_rdata", o_rdata, erd);
      return;
    end
    stalls = 1;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      i_dmem_ready = (k == waits);
      i_dmem_rdata = (k == waits) ? mem : $urandom;
      #1;
      if (o_stall) stalls++;
      chk("busy_stall", o_stall, 1);
      chk("busy_req", o_dmem_req, 1);
      chk("busy_we", o_dmem_we, !rd);
      chk("busy_addr", o_dmem_addr, a & 32'hFFFF_FFFC);
      chk("busy_rvalid", o_rvalid, 0);
      if (!rd) begin
        chk("busy_wstrb", o_dmem_wstrb, strb);
        chk("busy_wdata", o_dmem_wdata, ewd);
      end
    end
    @(negedge clk);
    i_dmem_ready = 1'b0;
    i_dmem_rdata = $urandom;
    if (!hold_in_done) drive_idle();
    #1;
    chk("done_rvalid", o_rvalid, 1);
    chk("done_stall", o_stall, 0);
    chk("done_req", o_dmem_req, 0);
    chk("done_bus_err", o_bus_err, 0);
    chk("stall_cycles", stalls, waits + 2);
    if (!hold_in_done) begin
      chk("done_rdata", o_rdata, erd);
      @(negedge clk); #1;
      chk("post_rvalid", o_rvalid, 0);
      return;
    end
    @(negedge clk); #1;
    chk("hold_idle_req", o_dmem_req, 0);
    chk("hold_idle_stall", o_stall, 1);
    chk("hold_idle_rvalid", o_rvalid, 0);
    @(negedge clk);
    i_dmem_ready = 1'b1;
    i_dmem_rdata = mem;
    #1;
    chk("hold_busy_req", o_dmem_req, 1);
    @(negedge clk);
    i_dmem_ready = 1'b0;
    drive_idle();
    #1;
    chk("hold_done_rvalid", o_rvalid, 1);
    chk("hold_done_rdata", o_rdata, erd);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          waits;
    logic        mis;
    logic [3:0]  strb;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [2:0] ld_f3s[8];
    logic [2:0] st_f3s[5];
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0, 4'h0, 32'h0,
                32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 3, 1'b0, 4'h0, 32'h0,
                32'h0000_80FF};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'hAB, 32'h0, 0, 1'b0, 4'b0010, 32'hABAB_ABAB,
                32'h0000_80FF};
    tbl[3]  = '{1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0000_80FF};
    tbl[4]  = '{1'b0, 1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0000_80FF};
    tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 1, 1'b0, 4'h0, 32'h0,
                32'hFFFF_80FF};
    tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h80FF_1234, 0, 1'b0, 4'h0, 32'h0,
                32'h0000_0012};
    tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 4'hF, 32'hDEAD_BEEF,
                32'h0000_0012};
    tbl[8]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 32'h0, 0, 1'b0, 4'b1100,
                32'h5678_5678, 32'h0000_0012};
    tbl[9]  = '{1'b1, 1'b0, 3'b111, 32'h108, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 4'h0, 32'h0,
                32'hCAFE_F00D};
    tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h10A, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'hCAFE_F00D};
    tbl[11] = '{1'b1, 1'b1, 3'b000, 32'h300, 32'hFFFF_FFFF, 32'h0000_0042, 0, 1'b0, 4'h0, 32'h0,
                32'h0000_0042};
    tbl[12] = '{1'b0, 1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0000_0042};
    tbl[13] = '{1'b0, 1'b1, 3'b000, 32'h200, 32'h1234_56CD, 32'h0, 0, 1'b0, 4'b0001,
                32'hCDCD_CDCD, 32'h0000_0042};

    ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    st_f3s = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

    // Reset state
    i_rst_n = 1'b0;
    drive_idle();
    i_dmem_ready = 1'b0;
    i_dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", o_stall, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_mis", o_misaligned, 0);
    chk("rst_bus_err", o_bus_err, 0);
    chk("rst_req", o_dmem_req, 0);
    chk("rst_we", o_dmem_we, 0);
    chk("rst_addr", o_dmem_addr, 0);
    chk("rst_wdata", o_dmem_wdata, 0);
    chk("rst_wstrb", o_dmem_wstrb, 0);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].mem,
                 tbl[i].waits, tbl[i].mis, tbl[i].strb, tbl[i].ewd, tbl[i].erd, 1'b0);
    end
    exp_rdata = 32'h0000_0042;

    // A load held through DONE must not restart until the following IDLE cycle
    run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h1122_3344, 0, 1'b0, 4'h0, 32'h0,
               32'h1122_3344, 1'b1);
    exp_rdata = 32'h1122_3344;

    // Reset in the second BUSY cycle of a load abandons it
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    i_dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    drive_idle();
    #1;
    chk("midrst_req", o_dmem_req, 0);
    chk("midrst_stall", o_stall, 0);
    chk("midrst_rvalid", o_rvalid, 0);
    chk("midrst_rdata", o_rdata, 0);
    exp_rdata = 32'h0;
    @(negedge clk); #1;
    chk("midrst_rvalid2", o_rvalid, 0);
    run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h5555_AAAA, 1, 1'b0, 4'h0, 32'h0,
               32'h5555_AAAA, 1'b0);
    exp_rdata = 32'h5555_AAAA;

`ifdef DMEM_TIMEOUT_EN
    // No ready ever: abort after four BUSY cycles
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    i_dmem_ready = 1'b0;
    #1;
    chk("to_idle_stall", o_stall, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("to_busy_req", o_dmem_req, 1);
      chk("to_busy_err", o_bus_err, 0);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("to_bus_err", o_bus_err, 1);
    chk("to_rvalid", o_rvalid, 0);
    chk("to_req", o_dmem_req, 0);
    chk("to_stall", o_stall, 0);
    chk("to_rdata", o_rdata, exp_rdata);
    @(negedge clk); #1;
    chk("to_err_end", o_bus_err, 0);
    chk("to_idle", o_stall, 0);
`endif

    // Random accesses against the model
    for (int n = 0; n < 80; n++) begin
      int          op;
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, wd, mem, erd;
      op  = $urandom_range(0, 9);
      rd  = (op >= 1 && op <= 5);
      wr  = (op >= 6) || (op == 3);
      f3  = rd ? ld_f3s[$urandom_range(0, 7)] : st_f3s[$urandom_range(0, 4)];
      a   = $urandom & 32'h0000_FFFF;
      wd  = $urandom;
      mem = $urandom;
      erd = exp_rdata;
      if (rd && !m_mis(f3, a)) erd = m_load(f3, a, mem);
      run_access(rd, wr, f3, a, wd, mem, $urandom_range(0, 2), m_mis(f3, a), m_strb(f3, a),
                 m_wdata(f3, wd), erd, 1'b0);
      exp_rdata = erd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
